// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for a single-round SHA-256 core: accepts block jobs,
// loads the core with the chaining value, steps it through the rounds while
// the scheduler keeps up, folds the result into H and presents the digest.
//
// state | meaning
// IDLE  | waiting for a block job
// LOAD  | core loads a..h from the chaining value
// ROUND | one round per cycle whenever the scheduler has Wt ready
// ACCUM | add core working variables into H, word by word
// DONE  | digest presented and held until the consumer takes it
module sha256_round_ctrl #(
  parameter int unsigned  ROUNDS = 64,
  parameter logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      abort,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic                      blk_first,
  input  logic                      blk_last,
  output logic                      sched_start,
  input  logic                      w_valid,
  output logic                      core_load,
  output logic                      core_step,
  output logic [$clog2(ROUNDS)-1:0] round_idx,
  output logic [255:0]              core_init_o,
  input  logic [255:0]              core_state_i,
  output logic [255:0]              digest,
  output logic                      digest_valid,
  input  logic                      digest_ready,
  output logic                      busy
);

  localparam int unsigned     RW       = $clog2(ROUNDS);
  localparam logic [RW-1:0]   LAST_RND = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [255:0] h_q;
  logic [255:0] h_sum;
  logic         last_q;
  logic         accept;
  logic         final_step;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/core control decode; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    blk_ready    = 1'b0;
    sched_start  = 1'b0;
    core_load    = 1'b0;
    core_step    = 1'b0;
    digest_valid = 1'b0;
    accept       = 1'b0;
    final_step   = 1'b0;
    case (state_q)
      S_IDLE: begin
        blk_ready   = !abort;
        accept      = blk_valid && !abort;
        sched_start = accept;
        if (accept) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_d   = S_ROUND;
      end
      S_ROUND: begin
        core_step  = w_valid;
        final_step = w_valid && (round_idx == LAST_RND);
        if (final_step) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        state_d = last_q ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // Per-word modulo-2^32 accumulation; carries never cross word boundaries.
  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i*32 +: 32] = h_q[i*32 +: 32] + core_state_i[i*32 +: 32];
    end
  end

  // Chaining value, round counter and latched last-block flag.
  // H returns to IV when a digest is taken so that a following job with
  // blk_first=0 starts from IV rather than from the previous message.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q       <= IV;
      round_idx <= '0;
      last_q    <= 1'b0;
    end else if (abort) begin
      h_q       <= IV;
      round_idx <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_q <= blk_last;
            if (blk_first) begin
              h_q <= IV;
            end
          end
        end
        S_LOAD: begin
          round_idx <= '0;
        end
        S_ROUND: begin
          if (core_step) begin
            round_idx <= final_step ? '0 : round_idx + RW'(1);
          end
        end
        S_ACCUM: begin
          h_q <= h_sum;
        end
        S_DONE: begin
          if (digest_ready) begin
            h_q <= IV;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign core_init_o = h_q;
  assign digest      = h_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: drives it with a behavioural SHA-256 round core
// and message scheduler, checks every output each cycle against a timeline
// model, and pins the model with known SHA-256 digests.
module tb_sha256_round_ctrl;

  localparam int           ROUNDS = 64;
  localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [2047:0] K_ALL = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] DIG_STUB = 256'h6a09e666bb67ae843c6ef371a54ff539510e527e9b05688b1f83d9aa5be0cd18;

  logic         clk          = 1'b0;
  logic         rst          = 1'b1;
  logic         abort        = 1'b0;
  logic         blk_valid    = 1'b0;
  logic         blk_first    = 1'b0;
  logic         blk_last     = 1'b0;
  logic         w_valid      = 1'b0;
  logic         digest_ready = 1'b0;
  logic         blk_ready;
  logic         sched_start;
  logic         core_load;
  logic         core_step;
  logic         digest_valid;
  logic         busy;
  logic [5:0]   round_idx;
  logic [255:0] core_init_o;
  logic [255:0] core_state_i;
  logic [255:0] digest;

  int n_cmp = 0;
  int n_err = 0;

  sha256_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .abort        (abort),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_first    (blk_first),
    .blk_last     (blk_last),
    .sched_start  (sched_start),
    .w_valid      (w_valid),
    .core_load    (core_load),
    .core_step    (core_step),
    .round_idx    (round_idx),
    .core_init_o  (core_init_o),
    .core_state_i (core_state_i),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Behavioural scheduler and round core reacting to the controller.
  logic [511:0] cur_blk    = '0;
  logic [255:0] st         = '0;
  logic         stub       = 1'b0;
  logic         rand_w     = 1'b0;
  logic [31:0]  w_arr [64];
  int           step_i     = 0;
  int           step_total = 0;

  assign core_state_i = stub ? '1 : st;

  // Core: load on core_load, one SHA-256 round per core_step using K/W at round_idx.
  always @(posedge clk) begin
    int ri;
    ri = int'(round_idx);
    if (sched_start) begin
      for (int t = 0; t < 16; t++) w_arr[t] = cur_blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) w_arr[t] = w_arr[t-16] + sig0(w_arr[t-15]) + w_arr[t-7] + sig1(w_arr[t-2]);
    end
    if (core_load) begin
      st     <= core_init_o;
      step_i = 0;
    end else if (core_step) begin
      check("round_idx_seq", 256'(round_idx), 256'(step_i));
      st <= sha_round(st, K_ALL[2047-32*ri -: 32], w_arr[ri]);
      step_i++;
      step_total++;
    end
  end

  // Timeline model: what the controller must be doing, derived from the accept
  // cycle, the number of rounds stepped so far, and the cycle of the final round.
  int           cyc    = 0;
  logic         m_busy = 1'b0;
  logic         m_dv   = 1'b0;
  logic         m_last = 1'b0;
  int           m_acc  = 0;
  int           m_n    = 0;
  int           m_fin  = -1;
  logic [255:0] m_h    = IV;

  // Advance the model with the inputs seen during the cycle that just ended.
  always @(posedge clk) begin
    int pc;
    cyc = cyc + 1;
    pc  = cyc - 1;
    if (rst || abort) begin
      m_busy = 1'b0;
      m_dv   = 1'b0;
      m_n    = 0;
      m_fin  = -1;
      m_h    = IV;
      if (rst) m_last = 1'b0;
    end else if (!m_busy) begin
      if (blk_valid) begin
        m_busy = 1'b1;
        m_acc  = pc;
        m_n    = 0;
        m_fin  = -1;
        m_last = blk_last;
        if (blk_first) m_h = IV;
      end
    end else if (m_fin < 0) begin
      if (pc >= m_acc + 2 && w_valid) begin
        m_n++;
        if (m_n == ROUNDS) m_fin = pc;
      end
    end else if (pc == m_fin + 1) begin
      for (int wi = 0; wi < 8; wi++) begin
        logic [31:0] hw, cw;
        hw = m_h[255-32*wi -: 32];
        cw = core_state_i[255-32*wi -: 32];
        m_h[255-32*wi -: 32] = hw + cw;
      end
      if (m_last) m_dv = 1'b1;
      else        m_busy = 1'b0;
    end else if (m_dv && digest_ready) begin
      m_dv   = 1'b0;
      m_busy = 1'b0;
      m_h    = IV;
    end
  end

  int   dv_rises = 0;
  logic dv_prev  = 1'b0;

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    logic in_rnd;
    in_rnd = m_busy && (m_fin < 0) && (cyc >= m_acc + 2);
    check("busy",         256'(busy),         256'(m_busy));
    check("blk_ready",    256'(blk_ready),    256'(!m_busy && !abort));
    check("sched_start",  256'(sched_start),  256'(!m_busy && !abort && blk_valid));
    check("core_load",    256'(core_load),    256'(m_busy && cyc == m_acc + 1));
    check("core_step",    256'(core_step),    256'(in_rnd && w_valid));
    check("round_idx",    256'(round_idx),    256'((m_busy && m_fin < 0) ? m_n : 0));
    check("digest_valid", 256'(digest_valid), 256'(m_dv));
    check("digest",       digest,             m_h);
    check("core_init_o",  core_init_o,        m_h);
    if (digest_valid && !dv_prev) dv_rises++;
    dv_prev = digest_valid;
  end

  // Scheduler word availability: always ready, or 50% random duty.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      w_valid = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [511:0] b, input logic first, input logic last, output int t_acc);
    int guard;
    guard     = 0;
    cur_blk   = b;
    blk_first = first;
    blk_last  = last;
    blk_valid = 1'b1;
    while (!blk_ready && guard < 300) begin
      tick();
      guard++;
    end
    if (!blk_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: blk_ready got 0 want 1");
    end
    t_acc = cyc;
    tick();
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_digest(input int budget, output int t_dv);
    int guard;
    guard = 0;
    while (!digest_valid && guard < budget) begin
      tick();
      guard++;
    end
    t_dv = cyc;
    if (!digest_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL digest_timeout: digest_valid got 0 want 1");
    end
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    int ta, td, g, s0, r0;

    repeat (2) tick();
    check("rst_digest", digest, IV);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_dv", 256'(digest_valid), 256'(0));
    check("rst_ridx", 256'(round_idx), 256'(0));
    check("rst_load", 256'(core_load), 256'(0));
    rst = 1'b0;
    tick();

    // Single block "abc", no stalls.
    digest_ready = 1'b1;
    send_block(BLK_ABC, 1'b1, 1'b1, ta);
    wait_digest(200, td);
    check("abc_latency", 256'(td), 256'(ta + 67));
    check("abc_digest", digest, DIG_ABC);
    tick();

    // Two-block message, one digest only.
    r0 = dv_rises;
    send_block(BLK_TWO1, 1'b1, 1'b0, ta);
    send_block(BLK_TWO2, 1'b0, 1'b1, ta);
    wait_digest(300, td);
    check("two_digest", digest, DIG_TWO);
    tick();
    check("two_dv_count", 256'(dv_rises - r0), 256'(1));

    // "abc" with a stalling scheduler.
    rand_w = 1'b1;
    s0     = step_total;
    send_block(BLK_ABC, 1'b1, 1'b1, ta);
    wait_digest(800, td);
    check("rand_digest", digest, DIG_ABC);
    check("rand_steps", 256'(step_total - s0), 256'(64));
    tick();
    rand_w = 1'b0;

    // Consumer holds off the digest; a new job must not slip in.
    digest_ready = 1'b0;
    send_block(BLK_ABC, 1'b1, 1'b1, ta);
    wait_digest(200, td);
    blk_valid = 1'b1;
    blk_first = 1'b1;
    blk_last  = 1'b1;
    repeat (10) begin
      check("stall_digest", digest, DIG_ABC);
      check("stall_ready", 256'(blk_ready), 256'(0));
      tick();
    end
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    check("stall_dv_held", 256'(digest_valid), 256'(1));
    digest_ready = 1'b1;
    tick();
    check("post_ready", 256'(blk_ready), 256'(1));
    check("post_dv", 256'(digest_valid), 256'(0));

    // Abort in IDLE blocks acceptance.
    blk_valid = 1'b1;
    abort     = 1'b1;
    #1;
    check("abort_idle_ready", 256'(blk_ready), 256'(0));
    check("abort_idle_sched", 256'(sched_start), 256'(0));
    tick();
    abort     = 1'b0;
    blk_valid = 1'b0;
    check("abort_idle_busy", 256'(busy), 256'(0));

    // Abort mid-message at round 30, then a clean "abc".
    send_block(BLK_ABC, 1'b1, 1'b1, ta);
    g = 0;
    while (round_idx != 6'd30 && g < 100) begin
      tick();
      g++;
    end
    check("abort_at_r30", 256'(round_idx), 256'(30));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ridx", 256'(round_idx), 256'(0));
    check("abort_h_iv", core_init_o, IV);
    r0 = dv_rises;
    repeat (70) tick();
    check("abort_no_dv", 256'(dv_rises - r0), 256'(0));
    send_block(BLK_ABC, 1'b1, 1'b1, ta);
    wait_digest(200, td);
    check("after_abort_digest", digest, DIG_ABC);
    tick();

    // Stub core of all-ones words, first=0 after a digest: chains from IV.
    stub = 1'b1;
    send_block(BLK_ABC, 1'b0, 1'b1, ta);
    wait_digest(200, td);
    check("stub_digest", digest, DIG_STUB);
    check("stub_h0", 256'(digest[255:224]), 256'(32'h6a09e666));
    check("stub_h7", 256'(digest[31:0]), 256'(32'h5be0cd18));
    tick();
    stub = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencing controller for the single-round SHA-256 hash core. It accepts 512-bit block jobs over a valid/ready handshake and loads the core with the chaining value. It then steps the core through 64 rounds, stalling whenever the message scheduler has no word ready. After each block it accumulates the core's working variables into the chaining registers and presents the digest after the last block of a message.

Parameters:
ROUNDS, 64, number of compression rounds per block; round_idx width is clog2(ROUNDS).
IV, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19, initial hash value H0..H7, packed with H0 in the MSBs.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
abort  in  1  synchronous abort of the current message.
blk_valid  in  1  block job offered.
blk_ready  out  1  controller can accept a job.
blk_first  in  1  job is the first block of a message; sampled on accept.
blk_last  in  1  job is the last block of a message; sampled on accept.
sched_start  out  1  one-cycle pulse telling the scheduler to begin producing W0..W63.
w_valid  in  1  scheduler word Wt is valid this cycle.
core_load  out  1  one-cycle pulse; core loads a..h from core_init_o.
core_step  out  1  core performs one round this cycle.
round_idx  out  6  round number; addresses the K ROM.
core_init_o  out  256  chaining value {H0..H7} to load into the core.
core_state_i  in  256  core working variables {a..h}, a in the MSBs.
digest  out  256  final hash {H0..H7}.
digest_valid  out  1  digest is valid; held until accepted.
digest_ready  in  1  consumer accepts the digest.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, H regs=IV, round_idx=0, latched first/last=0.
  - core_load, core_step, sched_start, digest_valid, busy all 0; digest=IV.
- blk_ready = (state==IDLE) && !abort. A job is accepted when blk_valid && blk_ready.
- States: IDLE, LOAD, ROUND, ACCUM, DONE.
- IDLE:
  - On accept: latch blk_first/blk_last; sched_start=1 in the same cycle (combinational).
  - If blk_first: H <= IV. Otherwise H is kept (chaining).
  - Next state is LOAD.
- LOAD:
  - core_load=1 for exactly one cycle; core_init_o = H; round_idx=0.
  - Next state is ROUND.
- ROUND:
  - core_step = w_valid, so the controller stalls while w_valid=0.
  - round_idx increments on each step.
  - On a step with round_idx==ROUNDS-1: round_idx wraps to 0; next state is ACCUM.
  - w_valid is ignored in every other state.
- ACCUM:
  - Each 32-bit word updates as H[i] <= H[i] + core_state_i[i], modulo 2^32 per word, with no carry between words.
  - If the latched last=1, next state is DONE; otherwise IDLE.
- DONE:
  - digest_valid=1; digest = H, held stable.
  - When digest_ready=1: next state IDLE, digest_valid drops the following cycle.
  - blk_ready=0 throughout DONE.
- Latency: accept at cycle T; core_load at T+1; steps at T+2..T+65 with no stalls; ACCUM at T+66; digest_valid at T+67. Each stall cycle adds 1.
- Core contract: core_state_i is valid in the cycle after the final step, which is the ACCUM cycle.
- abort:
  - Highest priority after rst. From any state the next state is IDLE.
  - H <= IV, round_idx <= 0; digest_valid drops on the next edge.
  - No accept occurs in the abort cycle.
- A job with blk_first=0 arriving after DONE or abort chains from IV. This is legal and is not flagged.
- blk_first=1 and blk_last=1 together form a single-block message.
- core_init_o is always driven with H; the core samples it only while core_load=1.

Test Plan:
- Single block "abc" (padded), w_valid held high, digest_ready=1 → digest_valid at accept+67; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1/last=0, then first=0/last=1) → one digest_valid only; digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with w_valid pseudo-random at 50% duty → identical digest; exactly 64 core_step pulses; round_idx sequence 0..63 with no skips or repeats.
- digest_ready=0 for 10 cycles after digest_valid → digest stable, blk_ready=0, a second blk_valid is not accepted; after digest_ready=1, blk_ready=1 the next cycle.
- abort asserted at round_idx=30 → IDLE the next cycle, no ACCUM or digest_valid; a following "abc" job gives the correct digest.
- Stub core returning core_state_i=all-ones words with IV chaining → H[i] = IV[i]-1 mod 2^32 (e.g. H0=6a09e666), confirming per-word wrap with no carry between words.
